// File: rtl/derate_match_input_buffer_writer.sv
// ---------------------------------------------------------------------------------------------
// derate_match_input_buffer_writer
//
// Write stage directly upstream of the per-user de-rate-matching input buffer bank. One session
// carries one user's serial LLR stream. LLRs are packed LLR_PER_WORD to a buffer word, with slot s
// occupying bits [LLR_W*s +: LLR_W], and each word is written to consecutive addresses starting
// at 0. The write data is broadcast to all user buffers and a one-hot enable selects the target
// buffer.
//
// Ports
//   i_core_clk   core clock, all logic on the rising edge
//   i_rx_rstn    asynchronous active-low reset
//   i_start      session start pulse, sampled only in IDLE
//   i_user_idx   target user buffer, captured with i_start
//   i_llr_num    number of LLRs in the session, captured with i_start
//   i_llr_valid  LLR input valid
//   i_llr_data   LLR sample (two's complement), stored unmodified
//   o_llr_ready  LLR input ready; a transfer happens on i_llr_valid && o_llr_ready
//   o_wr_addr    shared buffer write address, held between writes
//   o_wr_data    packed write word, held between writes
//   o_wr_en      one-hot write enable, one cycle per word
//   o_busy       high while a session is receiving or flushing
//   o_done       one-cycle pulse at session end
//   o_cfg_err    one-cycle pulse when a start is rejected for an oversized count
// ---------------------------------------------------------------------------------------------
module derate_match_input_buffer_writer #(
    parameter int unsigned LLR_W        = 6,
    parameter int unsigned LLR_PER_WORD = 6,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned NUM_USERS    = 16,
    parameter int unsigned CNT_W        = 14
) (
    input  logic                            i_core_clk,
    input  logic                            i_rx_rstn,
    input  logic                            i_start,
    input  logic [$clog2(NUM_USERS)-1:0]    i_user_idx,
    input  logic [CNT_W-1:0]                i_llr_num,
    input  logic                            i_llr_valid,
    input  logic [LLR_W-1:0]                i_llr_data,
    output logic                            o_llr_ready,
    output logic [ADDR_W-1:0]               o_wr_addr,
    output logic [LLR_W*LLR_PER_WORD-1:0]   o_wr_data,
    output logic [NUM_USERS-1:0]            o_wr_en,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_cfg_err
);

    localparam int unsigned DataW    = LLR_W * LLR_PER_WORD;
    localparam int unsigned UserW    = $clog2(NUM_USERS);
    localparam int unsigned SlotW    = (LLR_PER_WORD > 1) ? $clog2(LLR_PER_WORD) : 1;
    // One extra bit so the counter can reach the full buffer depth without wrapping.
    localparam int unsigned AddrCntW = ADDR_W + 1;
    // Largest session that still fits in one user buffer.
    localparam int unsigned MaxLlr   = (1 << ADDR_W) * LLR_PER_WORD;
    localparam logic [CNT_W-1:0] MaxLlrCnt = CNT_W'(MaxLlr);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StFlush,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [UserW-1:0]       user_q, user_d;
    logic [CNT_W-1:0]       num_q, num_d;
    logic [CNT_W-1:0]       llr_cnt_q, llr_cnt_d;
    logic [SlotW-1:0]       slot_q, slot_d;
    logic [DataW-1:0]       pack_q, pack_d;
    logic [AddrCntW-1:0]    addr_cnt_q, addr_cnt_d;
    logic [NUM_USERS-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DataW-1:0]       wr_data_q, wr_data_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [DataW-1:0]       pack_ins;
    logic                   last_llr;
    logic                   word_full;

    // Accepting this LLR completes the session / fills the top slot of the word.
    assign last_llr  = (llr_cnt_q + CNT_W'(1)) == num_q;
    assign word_full = slot_q == SlotW'(LLR_PER_WORD - 1);

    // Pack register with the incoming LLR dropped into the current slot.
    always_comb begin
        pack_ins = pack_q;
        for (int unsigned s = 0; s < LLR_PER_WORD; s++) begin
            if (slot_q == SlotW'(s)) begin
                pack_ins[s*LLR_W +: LLR_W] = i_llr_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        user_d     = user_q;
        num_d      = num_q;
        llr_cnt_d  = llr_cnt_q;
        slot_d     = slot_q;
        pack_d     = pack_q;
        addr_cnt_d = addr_cnt_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cfg_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_llr_num == '0) begin
                        state_d = StDone;
                    end else if (i_llr_num > MaxLlrCnt) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        user_d     = i_user_idx;
                        num_d      = i_llr_num;
                        llr_cnt_d  = '0;
                        slot_d     = '0;
                        pack_d     = '0;
                        addr_cnt_d = '0;
                        state_d    = StRecv;
                    end
                end
            end

            StRecv: begin
                if (i_llr_valid) begin
                    llr_cnt_d = llr_cnt_q + CNT_W'(1);
                    if (word_full || last_llr) begin
                        // Emit the word; the pack register restarts from zero so a short
                        // final word carries zeros in its unfilled slots.
                        wr_en_d[user_q] = 1'b1;
                        wr_addr_d       = addr_cnt_q[ADDR_W-1:0];
                        wr_data_d       = pack_ins;
                        addr_cnt_d      = addr_cnt_q + AddrCntW'(1);
                        pack_d          = '0;
                        slot_d          = '0;
                    end else begin
                        pack_d = pack_ins;
                        slot_d = slot_q + SlotW'(1);
                    end
                    if (last_llr) begin
                        state_d = StFlush;
                    end
                end
            end

            // The final word is on the write port during this cycle.
            StFlush: state_d = StDone;

            StDone: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q    <= StIdle;
            user_q     <= '0;
            num_q      <= '0;
            llr_cnt_q  <= '0;
            slot_q     <= '0;
            pack_q     <= '0;
            addr_cnt_q <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            user_q     <= user_d;
            num_q      <= num_d;
            llr_cnt_q  <= llr_cnt_d;
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            addr_cnt_q <= addr_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_llr_ready = (state_q == StRecv);
    assign o_busy      = (state_q == StRecv) || (state_q == StFlush);
    assign o_done      = (state_q == StDone);
    assign o_cfg_err   = cfg_err_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;

endmodule
